// File: rtl/seg_serial_tx_pkg.sv
// Shared definitions for the segment-image serial transmitter.
package seg_serial_tx_pkg;

    // 8 digits x 8 segments
    localparam int SEG_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        FIN   = 2'd3
    } tx_state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg_serial_tx_if.sv
// Parallel handshake between the segment decoder and the serial transmitter.
interface seg_serial_tx_if
    import seg_serial_tx_pkg::*;
#(
    parameter int WIDTH = SEG_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] par_data;
    logic             busy;
    logic             done;

    modport master (output start, output par_data, input busy, input done);
    modport slave  (input start, input par_data, output busy, output done);
endinterface

// File: rtl/seg_tick_gen.sv
// Strobe generator: tick is high on every HALF-th enabled cycle.
// clr restarts the count so the first tick lands HALF cycles after it drops.
module seg_tick_gen
    import seg_serial_tx_pkg::*;
#(
    parameter int HALF = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW = cnt_width(2 * HALF);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(HALF - 1));

    // Count enabled cycles within the current half period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/seg_serial_tx.sv
// Shifts a packed segment image LSB-first into the board's 74HC164 chain.
// Display is blanked (s_pen=0) while the chain is being loaded.
//
// state | meaning
// IDLE  | waiting for start, display on
// LOAD  | image captured, first bit on s_out, counters cleared
// SHIFT | one s_clk period per bit, low phase then high phase
// FIN   | done pulse, display back on
module seg_serial_tx
    import seg_serial_tx_pkg::*;
#(
    parameter int WIDTH = SEG_WIDTH,
    parameter int HALF  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    seg_serial_tx_if.slave     bus,
    output logic               s_clk,
    output logic               s_out,
    output logic               s_pen,
    output logic               s_clrn
);
    localparam int BCW = $clog2(WIDTH + 1);

    tx_state_t        state;
    logic [WIDTH-1:0] shreg;
    logic [BCW-1:0]   bit_cnt;
    logic             busy_q;
    logic             done_q;
    logic             tick;

    assign bus.busy = busy_q;
    assign bus.done = done_q;

    seg_tick_gen #(.HALF(HALF)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state != SHIFT),
        .en    (state == SHIFT),
        .tick  (tick)
    );

    // Frame sequencer with registered pin outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            s_clk   <= 1'b0;
            s_out   <= 1'b0;
            s_pen   <= 1'b0;
            s_clrn  <= 1'b0;
        end else begin
            s_clrn <= 1'b1;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    s_clk <= 1'b0;
                    s_pen <= 1'b1;
                    if (bus.start) begin
                        shreg  <= bus.par_data;
                        s_out  <= bus.par_data[0];
                        s_pen  <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    bit_cnt <= '0;
                    s_clk   <= 1'b0;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    if (tick) begin
                        if (!s_clk) begin
                            s_clk <= 1'b1;
                        end else begin
                            // end of high phase: advance to the next bit
                            s_clk   <= 1'b0;
                            shreg   <= shreg >> 1;
                            s_out   <= shreg[1];
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == BCW'(WIDTH - 1)) begin
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                                s_pen  <= 1'b1;
                                state  <= FIN;
                            end
                        end
                    end
                end
                FIN: begin
                    s_clk <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/seg_serial_tx.md
Name: seg_serial_tx

Overview:
- Consumes the 64-bit packed segment image produced by the hex-to-segment decoder.
- Byte layout, digit 7 (most-significant hex digit) down to digit 0:
  - digit 7 in [7:0], digit 6 in [15:8], ..., digit 0 in [63:56].
  - Within each byte: a=bit7, b=bit6, c=bit5, d=bit4, e=bit3, f=bit2, g=bit1, p=bit0.
- Shifts the image serially into the board's 74HC164 display shift-register chain.
- Sits between the segment decoder and the board pins; it is the transmitter for that packed interface.

Parameters:
- WIDTH, 64, number of bits shifted per frame (8 digits x 8 segments).
- HALF, 2, system-clock cycles per half period of s_clk; legal range is HALF >= 1.

Ports:
- clk  in  1  system clock; all state is updated on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request to transmit par_data; sampled only in IDLE.
- par_data  in  WIDTH  segment image (SEG_TXT format); captured when start is accepted.
- busy  out  1  high from the capture cycle through the end of SHIFT.
- done  out  1  one-cycle pulse when a frame has finished.
- s_clk  out  1  serial shift clock to the 74HC164 chain.
- s_out  out  1  serial data output.
- s_pen  out  1  display output enable; 1 = display on.
- s_clrn  out  1  active-low clear to the 74HC164 chain.

Behaviour:
- Reset (asynchronous, rst_n=0), applied immediately, including mid-frame:
  - state=IDLE, shift register=0, counters=0.
  - busy=0, done=0, s_clk=0, s_out=0, s_pen=0, s_clrn=0.
  - A frame interrupted by reset is discarded; no done is produced.
- After rst_n rises:
  - s_clrn goes to 1 at the first clk edge and stays 1.
  - s_pen goes to 1 at the first clk edge.
- States: IDLE, LOAD, SHIFT, FIN.
- IDLE:
  - busy=0, s_clk=0, s_pen=1.
  - If start=1, the next edge captures par_data into the shift register, sets busy=1 and moves to LOAD.
- LOAD (1 cycle):
  - s_out = shreg[0], s_pen = 0 (display blanked while shifting), s_clk = 0.
  - Clears the tick counter and bit counter; moves to SHIFT.
- SHIFT (exactly 2*HALF*WIDTH cycles):
  - Each bit is one s_clk period: s_clk low for HALF cycles, then high for HALF cycles.
  - s_out is stable throughout each bit period, so data is stable around every s_clk rising edge.
  - At the end of each high phase: s_clk returns to 0, the shift register shifts right by 1, s_out takes the new shreg[0], and the bit counter increments.
  - Bit order: par_data[0] first, par_data[WIDTH-1] last.
  - After the WIDTH-th high phase: move to FIN, with busy=0 and s_clk=0.
- FIN (1 cycle):
  - done=1, s_pen=1; return to IDLE.
  - start is ignored in FIN; it is accepted from IDLE on the next cycle.
- Timing from the start-sampling edge:
  - busy is high for exactly 1 + 2*HALF*WIDTH cycles.
  - done rises on the following edge.
- start while busy or in FIN: ignored and not queued.
- par_data changes after capture: no effect on the frame in flight.
- Counter widths:
  - bit counter: $clog2(WIDTH+1).
  - tick counter: $clog2(2*HALF), minimum 1 bit.
  - Counters wrap only through explicit clears; no modular overflow is relied upon.

Decomposition:
- Shared header holds:
  - state encodings: IDLE=2'd0, LOAD=2'd1, SHIFT=2'd2, FIN=2'd3;
  - the SEG_WIDTH=64 constant.
- Natural sub-module: seg_tick_gen, a HALF-cycle enable generator with synchronous clear. It is reused by other board serial drivers.

Test Plan (HALF=2, WIDTH=64 unless noted):
- Reset then idle: after rst_n rises, s_clrn=1 and s_pen=1 within 1 cycle; s_clk=0, busy=0, done=0 are held for 100 cycles.
- Single frame, par_data=64'h0123456789ABCDEF:
  - busy is high for exactly 257 cycles, then done pulses for 1 cycle.
  - Exactly 64 s_clk rising edges occur; bits sampled at those edges equal par_data LSB-first.
  - s_pen=0 throughout.
- Start while busy: a second start pulse with 64'hFFFF... at cycle 50 → ignored; the sampled stream still equals the first image; exactly one done.
- Back-to-back frames: start is held high continuously → each frame's done is followed by IDLE accepting start 1 cycle later; periodicity is 259 cycles.
- Reset mid-frame: rst_n=0 at bit 30 → s_clk, s_out, s_pen, busy and s_clrn all go to 0 without waiting for clk; no done; after release a new frame transmits correctly.
- HALF=1: busy lasts 129 cycles; s_clk has a 2-cycle period with 50% duty; the data stream is correct.
